monster_hp_arbiter: RTL and testbench

Parametrised HP-event arbiter between the N monster units and the shared HP/lives counter. It collects per-monster add/remove HP requests, buffers any that lose arbitration so no event is lost, and issues at most one add and one remove per clock. A granted removal pulses `pacmanRespawn` and opens a respawn hold-off window in which further removals are discarded.

---
 rtl/monster_hp_arbiter_if.sv | 35 +++
 rtl/monster_hp_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_monster_hp_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/monster_hp_arbiter_if.sv
// monster_hp_arbiter_if: request/grant bundle between the monster units
// (master side) and the HP event arbiter (slave side).
// Channel i of each packed request bus occupies bits [i*HP_W +: HP_W].
interface monster_hp_arbiter_if #(
    parameter int N_MON = 4,
    parameter int HP_W  = 5
);
    logic [N_MON*HP_W-1:0] addHPIn;
    logic [N_MON*HP_W-1:0] removeHPIn;
    logic [HP_W-1:0]       addHPmonsters;
    logic [HP_W-1:0]       removeHPmonsters;
    logic                  pacmanRespawn;
    logic                  holdActive;
    logic                  removeDropped;

    modport master (
        output addHPIn,
        output removeHPIn,
        input  addHPmonsters,
        input  removeHPmonsters,
        input  pacmanRespawn,
        input  holdActive,
        input  removeDropped
    );

    modport slave (
        input  addHPIn,
        input  removeHPIn,
        output addHPmonsters,
        output removeHPmonsters,
        output pacmanRespawn,
        output holdActive,
        output removeDropped
    );
endinterface

// File: rtl/monster_hp_arbiter.sv
// monster_hp_arbiter: merges per-monster add/remove HP requests with
// per-channel pending buffers (saturating), grants at most one add and one
// remove per clock, and enforces a respawn hold-off after each granted removal.
// Optional feature macro: MONSTER_HP_RR_EN selects round-robin arbitration
// (separate add/remove pointers); when undefined, lowest channel index wins.
module monster_hp_arbiter #(
    parameter int N_MON        = 4,
    parameter int HP_W         = 5,
    parameter int RESPAWN_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    monster_hp_arbiter_if.slave  bus
);
    localparam int              PTR_W     = (N_MON > 1) ? $clog2(N_MON) : 1;
    localparam logic [HP_W-1:0] HP_MAX    = '1;
    localparam logic [7:0]      HOLD_LOAD = 8'(RESPAWN_HOLD);

    logic [HP_W-1:0]  add_merged [N_MON];
    logic [HP_W-1:0]  rem_merged [N_MON];
    logic [N_MON-1:0] add_req;
    logic [N_MON-1:0] rem_req;
    logic [PTR_W-1:0] add_ptr;
    logic [PTR_W-1:0] rem_ptr;
    logic [PTR_W-1:0] add_gnt;
    logic [PTR_W-1:0] rem_gnt;
    logic             add_found;
    logic             rem_found;

    logic [7:0]       hold_q,    hold_d;
    logic [HP_W-1:0]  add_out_q, add_out_d;
    logic [HP_W-1:0]  rem_out_q, rem_out_d;
    logic             respawn_q, respawn_d;
    logic             dropped_q, dropped_d;

    // Search req starting at index 'start' (wrapping); returns {found, index}.
    function automatic logic [PTR_W:0] pick(input logic [N_MON-1:0] req,
                                            input logic [PTR_W-1:0] start);
        logic [2*N_MON-1:0] dbl;
        logic [N_MON-1:0]   rot;
        logic [PTR_W:0]     idx;
        logic               found;
        dbl   = {req, req};
        rot   = dbl[start +: N_MON];
        found = 1'b0;
        idx   = '0;
        // Walk from the far end so the nearest request to 'start' wins.
        for (int k = N_MON - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = {1'b0, start} + (PTR_W+1)'(k);
            end
        end
        if (idx >= (PTR_W+1)'(N_MON)) begin
            idx = idx - (PTR_W+1)'(N_MON);
        end
        return {found, idx[PTR_W-1:0]};
    endfunction

    // Per-channel merge of pending + new request and pending-register update.
    for (genvar gi = 0; gi < N_MON; gi++) begin : g_chan
        logic [HP_W-1:0] add_pend_q, add_pend_d;
        logic [HP_W-1:0] rem_pend_q, rem_pend_d;
        logic [HP_W:0]   add_sum;
        logic [HP_W:0]   rem_sum;

        // A plain sum already covers the "only one side nonzero" case.
        assign add_sum        = {1'b0, add_pend_q} + {1'b0, bus.addHPIn[gi*HP_W +: HP_W]};
        assign rem_sum        = {1'b0, rem_pend_q} + {1'b0, bus.removeHPIn[gi*HP_W +: HP_W]};
        assign add_merged[gi] = add_sum[HP_W] ? HP_MAX : add_sum[HP_W-1:0];
        assign rem_merged[gi] = rem_sum[HP_W] ? HP_MAX : rem_sum[HP_W-1:0];
        assign add_req[gi]    = |add_merged[gi];
        assign rem_req[gi]    = |rem_merged[gi];

        // Losers keep their merged value; the winner (or everyone during hold-off) clears.
        always_comb begin
            add_pend_d = add_merged[gi];
            rem_pend_d = rem_merged[gi];
            if (add_found && add_gnt == PTR_W'(gi)) begin
                add_pend_d = '0;
            end
            if (hold_q != 8'd0 || (rem_found && rem_gnt == PTR_W'(gi))) begin
                rem_pend_d = '0;
            end
        end

        // Pending buffers, dropped by reset.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                add_pend_q <= '0;
                rem_pend_q <= '0;
            end else begin
                add_pend_q <= add_pend_d;
                rem_pend_q <= rem_pend_d;
            end
        end
    end

`ifdef MONSTER_HP_RR_EN
    logic [PTR_W-1:0] add_ptr_q, add_ptr_d;
    logic [PTR_W-1:0] rem_ptr_q, rem_ptr_d;

    function automatic logic [PTR_W-1:0] next_ch(input logic [PTR_W-1:0] g);
        return (g == PTR_W'(N_MON - 1)) ? '0 : g + 1'b1;
    endfunction

    assign add_ptr = add_ptr_q;
    assign rem_ptr = rem_ptr_q;

    // Pointers move past the last winner; the remove pointer is frozen in hold-off.
    always_comb begin
        add_ptr_d = add_ptr_q;
        rem_ptr_d = rem_ptr_q;
        if (add_found) begin
            add_ptr_d = next_ch(add_gnt);
        end
        if (hold_q == 8'd0 && rem_found) begin
            rem_ptr_d = next_ch(rem_gnt);
        end
    end

    // Round-robin pointer registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            add_ptr_q <= '0;
            rem_ptr_q <= '0;
        end else begin
            add_ptr_q <= add_ptr_d;
            rem_ptr_q <= rem_ptr_d;
        end
    end
`else
    // Fixed priority: every search starts at channel 0.
    assign add_ptr = '0;
    assign rem_ptr = '0;
`endif

    // Independent winner selection for the add and remove paths.
    always_comb begin
        {add_found, add_gnt} = pick(add_req, add_ptr);
        {rem_found, rem_gnt} = pick(rem_req, rem_ptr);
    end

    // Grant outputs and hold-off counter; the counter never reloads while nonzero.
    always_comb begin
        add_out_d = add_found ? add_merged[add_gnt] : '0;
        rem_out_d = '0;
        respawn_d = 1'b0;
        dropped_d = 1'b0;
        hold_d    = hold_q;
        if (hold_q != 8'd0) begin
            hold_d    = hold_q - 8'd1;
            dropped_d = |rem_req;
        end else if (rem_found) begin
            rem_out_d = rem_merged[rem_gnt];
            respawn_d = 1'b1;
            hold_d    = HOLD_LOAD;
        end
    end

    // Registered outputs and hold counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_q    <= '0;
            add_out_q <= '0;
            rem_out_q <= '0;
            respawn_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            add_out_q <= add_out_d;
            rem_out_q <= rem_out_d;
            respawn_q <= respawn_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.addHPmonsters    = add_out_q;
    assign bus.removeHPmonsters = rem_out_q;
    assign bus.pacmanRespawn    = respawn_q;
    assign bus.removeDropped    = dropped_q;
    assign bus.holdActive       = (hold_q != 8'd0);
endmodule

// File: tb/tb_monster_hp_arbiter.sv
// tb_monster_hp_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_monster_hp_arbiter;
    localparam int N    = 4;
    localparam int W    = 5;
    localparam int RH   = 16;
    localparam int MAXV = 31;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    monster_hp_arbiter_if #(.N_MON(N), .HP_W(W)) bus ();

    monster_hp_arbiter #(.N_MON(N), .HP_W(W), .RESPAWN_HOLD(RH)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int ain [N];
    int rin [N];
    int m_addp [N];
    int m_remp [N];
    int m_hold;
    int m_aptr;
    int m_rptr;
    int e_add, e_rem, e_resp, e_drop;
    int cyc_no = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    function automatic int sat(input int a, input int b);
        return (a + b > MAXV) ? MAXV : a + b;
    endfunction

    // First nonzero entry scanning from 'start' with wrap-around, -1 if none.
    function automatic int pick(input int v [N], input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N] != 0) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_addp[i] = 0;
            m_remp[i] = 0;
        end
        m_hold = 0; m_aptr = 0; m_rptr = 0;
        e_add = 0; e_rem = 0; e_resp = 0; e_drop = 0;
    endtask

    // One clock edge worth of arbiter behaviour, using the inputs in ain/rin.
    task automatic model_step();
        int am [N];
        int rm [N];
        int w;
        for (int i = 0; i < N; i++) begin
            am[i] = sat(m_addp[i], ain[i]);
            rm[i] = sat(m_remp[i], rin[i]);
        end
        w = pick(am, m_aptr);
        e_add = (w >= 0) ? am[w] : 0;
        for (int i = 0; i < N; i++) m_addp[i] = (i == w) ? 0 : am[i];
`ifdef MONSTER_HP_RR_EN
        if (w >= 0) m_aptr = (w + 1) % N;
`endif
        e_rem = 0; e_resp = 0; e_drop = 0;
        if (m_hold == 0) begin
            w = pick(rm, m_rptr);
            if (w >= 0) begin
                e_rem  = rm[w];
                e_resp = 1;
                m_hold = RH;
`ifdef MONSTER_HP_RR_EN
                m_rptr = (w + 1) % N;
`endif
            end
            for (int i = 0; i < N; i++) m_remp[i] = (i == w) ? 0 : rm[i];
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rm[i] != 0) e_drop = 1;
                m_remp[i] = 0;
            end
            m_hold = m_hold - 1;
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.addHPIn[i*W +: W]    = W'(ain[i]);
            bus.removeHPIn[i*W +: W] = W'(rin[i]);
        end
    endtask

    task automatic clear_in();
        for (int i = 0; i < N; i++) begin
            ain[i] = 0;
            rin[i] = 0;
        end
        apply();
    endtask

    // Advance one edge, update the model and compare every output.
    task automatic tick();
        @(posedge clk);
        cyc_no++;
        if (resetN) model_step();
        #1;
        check("addHPmonsters",    int'(bus.addHPmonsters),    e_add);
        check("removeHPmonsters", int'(bus.removeHPmonsters), e_rem);
        check("pacmanRespawn",    int'(bus.pacmanRespawn),    e_resp);
        check("removeDropped",    int'(bus.removeDropped),    e_drop);
        check("holdActive",       int'(bus.holdActive),       (m_hold != 0) ? 1 : 0);
        if (e_add != 0 || e_rem != 0 || e_drop != 0)
            $display("cycle %0d: add=%0d rem=%0d respawn=%0d dropped=%0d",
                     cyc_no, e_add, e_rem, e_resp, e_drop);
    endtask

    // Drive the current ain/rin for one edge, then return inputs to idle.
    task automatic step();
        apply();
        tick();
        clear_in();
    endtask

    int hold_cycles;
    int stale;

    initial begin
        model_reset();
        clear_in();
        #3;
        check("reset addHPmonsters",    int'(bus.addHPmonsters), 0);
        check("reset removeHPmonsters", int'(bus.removeHPmonsters), 0);
        check("reset holdActive",       int'(bus.holdActive), 0);
        #9 resetN = 1'b1;

        // Single add on ch2.
        ain[2] = 3;
        step();
        check("single add value", int'(bus.addHPmonsters), 3);
        check("single add no respawn", int'(bus.pacmanRespawn), 0);
        step();
        check("single add gone", int'(bus.addHPmonsters), 0);

        // Contention ch0 vs ch3: both delivered, one per cycle.
        ain[0] = 1; ain[3] = 4;
        step();
        check("contention first", int'(bus.addHPmonsters), 1);
        step();
        check("contention second", int'(bus.addHPmonsters), 4);

`ifndef MONSTER_HP_RR_EN
        // Saturation: ch1 blocked twice by ch0, its buffered 20+20 clamps to 31.
        ain[0] = 1; ain[1] = 20;
        step();
        ain[0] = 1; ain[1] = 20;
        step();
        step();
        check("saturated add", int'(bus.addHPmonsters), 31);
`endif
        repeat (2) step();

        // Hold-off window after a granted removal.
        rin[0] = 1;
        step();
        check("first remove value", int'(bus.removeHPmonsters), 1);
        check("first remove respawn", int'(bus.pacmanRespawn), 1);
        hold_cycles = bus.holdActive ? 1 : 0;
        for (int off = 1; off <= 17; off++) begin
            if (off == 5)  rin[1] = 1;
            if (off == 16) rin[2] = 2;
            if (off == 17) rin[3] = 3;
            step();
            if (off <= 16 && bus.holdActive) hold_cycles++;
            if (off == 5) begin
                check("dropped in hold", int'(bus.removeDropped), 1);
                check("no remove in hold", int'(bus.removeHPmonsters), 0);
            end
            if (off == 16) check("dropped at last hold edge", int'(bus.removeDropped), 1);
            if (off == 17) begin
                check("remove after hold", int'(bus.removeHPmonsters), 3);
                check("respawn after hold", int'(bus.pacmanRespawn), 1);
            end
        end
        check("hold length", hold_cycles, RH);
        repeat (RH + 2) step();

        // Asynchronous reset in the middle of a hold with adds still buffered.
        ain[0] = 5; ain[1] = 7; ain[3] = 9; rin[2] = 4;
        step();
        check("pre-reset add", int'(bus.addHPmonsters), 5);
        #2 resetN = 1'b0;
        #1;
        model_reset();
        check("async reset add",     int'(bus.addHPmonsters), 0);
        check("async reset remove",  int'(bus.removeHPmonsters), 0);
        check("async reset respawn", int'(bus.pacmanRespawn), 0);
        check("async reset hold",    int'(bus.holdActive), 0);
        #3 resetN = 1'b1;
        stale = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.addHPmonsters != 0 || bus.removeHPmonsters != 0) stale++;
        end
        check("no stale events after reset", stale, 0);

        // Random traffic: sparse bursts with occasional quiet stretches.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                ain[i] = ($urandom_range(3) == 0) ? int'($urandom_range(MAXV, 1)) : 0;
                rin[i] = ($urandom_range(9) == 0) ? int'($urandom_range(MAXV, 1)) : 0;
            end
            if ((c / 50) % 4 == 3) begin
                for (int i = 0; i < N; i++) begin
                    ain[i] = 0;
                    rin[i] = 0;
                end
            end
            step();
        end
        repeat (RH + 4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
